inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 The module SHALL have port CLK  input  1  the single clock; all state updates on posedge.
REQ-003 The module SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port IMEM_REQ  output  1  fetch request to instruction memory.
REQ-005 The module SHALL have port IMEM_ADDR  output  32  fetch byte address, word-aligned.
REQ-006 The module SHALL have port IMEM_ACK  input  1  one-cycle pulse; IMEM_RDATA valid this cycle.
REQ-007 The module SHALL have port IMEM_RDATA  input  32  fetched instruction word.
REQ-008 The module SHALL have port REDIRECT  input  1  taken branch/jump; flush queue and refetch.
REQ-009 The module SHALL have port REDIRECT_PC  input  32  new fetch address; bits [1:0] ignored.
REQ-010 The module SHALL have port INST_VALID  output  1  queue head holds a valid instruction.
REQ-011 The module SHALL have port INST  output  32  queue head instruction word.
REQ-012 The module SHALL have port INST_PC  output  32  byte address of INST.
REQ-013 The module SHALL have port INST_READY  input  1  decode consumes the head this cycle when INST_VALID=1.

Function
REQ-014 The module SHALL keep a fetch PC register and a 2-entry FIFO of {PC, instruction} pairs with a 2-bit count (0..2).
REQ-015 The FSM SHALL have three states: IDLE (no request outstanding), WAIT (request outstanding, result kept), DROP (request outstanding, result discarded).
REQ-016 IDLE SHALL move to WAIT when count<=1 and REDIRECT=0, driving IMEM_REQ=1 and IMEM_ADDR=PC from that cycle.
REQ-017 In WAIT/DROP, IMEM_REQ SHALL stay 1 and IMEM_ADDR SHALL stay stable until the IMEM_ACK cycle, then IMEM_REQ SHALL be 0 for at least one cycle (IDLE).
REQ-018 On IMEM_ACK in WAIT with REDIRECT=0, {PC, IMEM_RDATA} SHALL be pushed, PC SHALL become PC+4 (mod 2^32, wraps to 0), and the state SHALL return to IDLE.
REQ-019 Only one request SHALL be outstanding; with issue restricted to count<=1 the FIFO SHALL never overflow.
REQ-020 INST_VALID SHALL equal (count!=0); INST/INST_PC SHALL show the head entry and be 0 when empty.
REQ-021 Pop SHALL occur when INST_VALID=1 and INST_READY=1; simultaneous push and pop SHALL leave count unchanged and keep order.
REQ-022 INST_READY with INST_VALID=0 SHALL have no effect.
REQ-023 On REDIRECT: the FIFO SHALL be flushed (count=0), PC SHALL load {REDIRECT_PC[31:2],2'b00}; any same-cycle pop or push SHALL be discarded.
REQ-024 REDIRECT in WAIT without IMEM_ACK SHALL move to DROP; REDIRECT in DROP SHALL update PC and stay in DROP.
REQ-025 IMEM_ACK in DROP SHALL discard IMEM_RDATA, leave PC unchanged, and go to IDLE.
REQ-026 REDIRECT coincident with IMEM_ACK (WAIT or DROP) SHALL discard the data and go to IDLE with PC = redirected value.
REQ-027 Latency: an instruction acked in cycle N SHALL appear with INST_VALID=1 in cycle N+1; a request for the redirect PC SHALL start no earlier than the cycle after REDIRECT.

Reset
REQ-028 With RST=1 at posedge: PC=RESET_PC, count=0, FIFO pointers=0, state=IDLE; IMEM_REQ=0, IMEM_ADDR=RESET_PC, INST_VALID=0, INST=0, INST_PC=0.
REQ-029 RST SHALL override every other input, including mid-request; an IMEM_ACK arriving after reset for a pre-reset request SHALL be ignored unless a new request is outstanding.
REQ-030 IMEM_REQ SHALL first assert in the cycle after RST deasserts.

Verification
REQ-031 Reset release, memory acks 1 cycle after each request, INST_READY=1 -> INST_PC sequence 0,4,8,12 with matching words, no gaps beyond the request/idle bubble.
REQ-032 INST_READY=0, acks for 0x0 and 0x4 -> count=2, IMEM_REQ stays 0, INST_PC=0x0 held; raise INST_READY -> 0x0 then 0x4 pop in order.
REQ-033 REDIRECT to 0x103 while waiting on 0x8 -> DROP, IMEM_ADDR stays 0x8 until ack, data discarded, next request IMEM_ADDR=0x100, INST_VALID=0 throughout.
REQ-034 REDIRECT to 0x40 in same cycle as IMEM_ACK and pop with count=1 -> count=0, data dropped, next IMEM_ADDR=0x40.
REQ-035 RESET_PC=32'hFFFF_FFFC, one ack -> INST_PC=0xFFFF_FFFC, next IMEM_ADDR=0x0.
REQ-036 RST asserted in WAIT with stray ack next cycle -> all outputs at reset values, no push.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetcher with a 2-entry {pc, inst} queue; one memory request in flight, acked word visible the cycle after ack.
// New requests issue only while the queue has room for the reply (count<=1); decode stalls simply hold the head.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INST_VALID,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  input  logic        INST_READY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr;
  logic [1:0]  count;
  logic        wr_ptr, rd_ptr;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        issue, push, pop;
  logic        unused_bits;

  assign unused_bits = ^REDIRECT_PC[1:0];

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count <= 2'd1 && !REDIRECT) begin
          state_nxt = ST_WAIT;
          issue     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (IMEM_ACK)      state_nxt = ST_IDLE;
        else if (REDIRECT) state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (IMEM_ACK) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A redirect kills both the returning word and any decode handshake in the same cycle.
  assign push = (state == ST_WAIT) && IMEM_ACK && !REDIRECT;
  assign pop  = INST_VALID && INST_READY && !REDIRECT;

  always_comb begin
    pc_nxt = pc;
    if (REDIRECT)  pc_nxt = {REDIRECT_PC[31:2], 2'b00};
    else if (push) pc_nxt = pc + 32'd4;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (issue) req_addr <= pc;
      if (REDIRECT) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_inst[wr_ptr] <= IMEM_RDATA;
    end
  end

  assign IMEM_REQ   = (state != ST_IDLE);
  assign IMEM_ADDR  = req_addr;
  assign INST_VALID = (count != 2'd0);
  assign INST       = INST_VALID ? fifo_inst[rd_ptr] : 32'd0;
  assign INST_PC    = INST_VALID ? fifo_pc[rd_ptr]   : 32'd0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, wrap-around instance, and randomized run against a queue model.
module tb_inst_fetch_queue;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, ack, redir, ready;
  logic [31:0] rdata, rpc;
  logic        req, valid;
  logic [31:0] addr, inst, ipc;

  logic        rst2, ack2, redir2, ready2;
  logic [31:0] rdata2, rpc2;
  logic        req2, valid2;
  logic [31:0] addr2, inst2, ipc2;

  inst_fetch_queue dut (
    .CLK(CLK), .RST(rst), .IMEM_REQ(req), .IMEM_ADDR(addr), .IMEM_ACK(ack),
    .IMEM_RDATA(rdata), .REDIRECT(redir), .REDIRECT_PC(rpc), .INST_VALID(valid),
    .INST(inst), .INST_PC(ipc), .INST_READY(ready)
  );

  inst_fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RST(rst2), .IMEM_REQ(req2), .IMEM_ADDR(addr2), .IMEM_ACK(ack2),
    .IMEM_RDATA(rdata2), .REDIRECT(redir2), .REDIRECT_PC(rpc2), .INST_VALID(valid2),
    .INST(inst2), .INST_PC(ipc2), .INST_READY(ready2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, ack, redir, ready;
    logic [31:0] rdata, rpc;
    logic        req, chk_addr;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc, inst;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                              input logic rd, input logic [31:0] rp, input logic rdy,
                              input logic eq, input logic ca, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = d; v.redir = rd; v.rpc = rp; v.ready = rdy;
    v.req = eq; v.chk_addr = ca; v.addr = ea; v.valid = ev; v.ipc = ep; v.inst = ei;
    return v;
  endfunction

  // Reference model: fetch pc, one outstanding request with a discard flag, and a queue of entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_addr;
  bit          m_busy, m_drop, m_addr_known;

  task automatic model_step(input logic r, input logic a, input logic [31:0] d,
                            input logic rd, input logic [31:0] rp, input logic rdy);
    int          sz;
    logic [31:0] pc0;
    bit          issue;
    sz  = mq.size();
    pc0 = m_pc;
    if (r) begin
      mq.delete();
      m_pc = 32'd0; m_addr = 32'd0;
      m_busy = 0; m_drop = 0; m_addr_known = 1;
      return;
    end
    issue = !m_busy && sz <= 1 && !rd;
    if (!rd && sz > 0 && rdy) void'(mq.pop_front());
    if (m_busy && a && !m_drop && !rd) begin
      ent_t e;
      e.pc = pc0; e.inst = d;
      mq.push_back(e);
      m_pc = pc0 + 32'd4;
    end
    if (rd) begin
      mq.delete();
      m_pc = {rp[31:2], 2'b00};
    end
    if (m_busy) begin
      if (a) begin m_busy = 0; m_drop = 0; end
      else if (rd) m_drop = 1;
    end else if (issue) begin
      m_busy = 1; m_drop = 0; m_addr = pc0;
    end
    m_addr_known = m_busy;
  endtask

  vec_t tbl[21];

  initial begin
    rst = 1; ack = 0; redir = 0; ready = 0; rdata = 0; rpc = 0;
    rst2 = 1; ack2 = 0; redir2 = 0; ready2 = 0; rdata2 = 0; rpc2 = 0;

    tbl[0]  = mk(1, 0, 32'h0,         0, 32'h0,   1, 0, 1, 32'h0,   0, 32'h0,   32'h0);
    tbl[1]  = mk(0, 0, 32'h0,         0, 32'h0,   1, 1, 1, 32'h0,   0, 32'h0,   32'h0);
    tbl[2]  = mk(0, 1, 32'hA000_0000, 0, 32'h0,   1, 0, 0, 32'h0,   1, 32'h0,   32'hA000_0000);
    tbl[3]  = mk(0, 0, 32'h0,         0, 32'h0,   1, 1, 1, 32'h4,   0, 32'h0,   32'h0);
    tbl[4]  = mk(0, 1, 32'hA000_0001, 0, 32'h0,   1, 0, 0, 32'h0,   1, 32'h4,   32'hA000_0001);
    tbl[5]  = mk(0, 0, 32'h0,         0, 32'h0,   0, 1, 1, 32'h8,   1, 32'h4,   32'hA000_0001);
    tbl[6]  = mk(0, 1, 32'hA000_0002, 0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h4,   32'hA000_0001);
    tbl[7]  = mk(0, 0, 32'h0,         0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h4,   32'hA000_0001);
    tbl[8]  = mk(0, 0, 32'h0,         0, 32'h0,   1, 0, 0, 32'h0,   1, 32'h8,   32'hA000_0002);
    tbl[9]  = mk(0, 0, 32'h0,         0, 32'h0,   0, 1, 1, 32'hC,   1, 32'h8,   32'hA000_0002);
    tbl[10] = mk(0, 0, 32'h0,         1, 32'h103, 0, 1, 1, 32'hC,   0, 32'h0,   32'h0);
    tbl[11] = mk(0, 1, 32'hA000_0003, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   32'h0);
    tbl[12] = mk(0, 0, 32'h0,         0, 32'h0,   0, 1, 1, 32'h100, 0, 32'h0,   32'h0);
    tbl[13] = mk(0, 1, 32'hA000_0004, 0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h100, 32'hA000_0004);
    tbl[14] = mk(0, 0, 32'h0,         0, 32'h0,   0, 1, 1, 32'h104, 1, 32'h100, 32'hA000_0004);
    tbl[15] = mk(0, 1, 32'hA000_0005, 1, 32'h40,  1, 0, 0, 32'h0,   0, 32'h0,   32'h0);
    tbl[16] = mk(0, 0, 32'h0,         0, 32'h0,   0, 1, 1, 32'h40,  0, 32'h0,   32'h0);
    tbl[17] = mk(1, 0, 32'h0,         0, 32'h0,   0, 0, 1, 32'h0,   0, 32'h0,   32'h0);
    tbl[18] = mk(0, 1, 32'hA000_0006, 0, 32'h0,   1, 1, 1, 32'h0,   0, 32'h0,   32'h0);
    tbl[19] = mk(0, 0, 32'h0,         0, 32'h0,   1, 1, 1, 32'h0,   0, 32'h0,   32'h0);
    tbl[20] = mk(0, 1, 32'hA000_0007, 0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h0,   32'hA000_0007);

    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; ack = tbl[i].ack; rdata = tbl[i].rdata;
      redir = tbl[i].redir; rpc = tbl[i].rpc; ready = tbl[i].ready;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_req", i), {31'd0, req}, {31'd0, tbl[i].req});
      if (tbl[i].chk_addr) chk($sformatf("vec%0d_addr", i), addr, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].valid});
      chk($sformatf("vec%0d_inst_pc", i), ipc, tbl[i].ipc);
      chk($sformatf("vec%0d_inst", i), inst, tbl[i].inst);
    end

    // PC wrap from the top word of the address space.
    rst2 = 1;
    @(posedge CLK); #1;
    chk("wrap_reset_req", {31'd0, req2}, 32'd0);
    chk("wrap_reset_addr", addr2, 32'hFFFF_FFFC);
    rst2 = 0;
    @(posedge CLK); #1;
    chk("wrap_req", {31'd0, req2}, 32'd1);
    chk("wrap_addr", addr2, 32'hFFFF_FFFC);
    ack2 = 1; rdata2 = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    ack2 = 0;
    chk("wrap_valid", {31'd0, valid2}, 32'd1);
    chk("wrap_inst_pc", ipc2, 32'hFFFF_FFFC);
    chk("wrap_inst", inst2, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    chk("wrap_next_req", {31'd0, req2}, 32'd1);
    chk("wrap_next_addr", addr2, 32'h0);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      rst   = (c == 0) || ($urandom_range(0, 99) == 0);
      redir = ($urandom_range(0, 11) == 0);
      rpc   = $urandom;
      ready = ($urandom_range(0, 9) < 6);
      rdata = $urandom;
      ack   = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      @(posedge CLK);
      model_step(rst, ack, rdata, redir, rpc, ready);
      #1;
      chk("rnd_req", {31'd0, req}, {31'd0, m_busy});
      if (m_addr_known) chk("rnd_addr", addr, m_addr);
      chk("rnd_valid", {31'd0, valid}, {31'd0, (mq.size() != 0)});
      chk("rnd_inst_pc", ipc, (mq.size() != 0) ? mq[0].pc : 32'd0);
      chk("rnd_inst", inst, (mq.size() != 0) ? mq[0].inst : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
